// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, two-flop input synchroniser, valid/ready holding register.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority bit decisions when latched divider >= 3.
module uart_rx (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    input  logic [15:0] i_divider,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_frame_err,
    output logic        o_overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic        armed;
    logic [15:0] div_q;
    logic [16:0] cnt;
    logic [16:0] period;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_val;

    assign period = {div_q, 1'b0};
    assign o_busy = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early;

    // Captures rx_s at counter values 2 and 1; the third vote is rx_s at counter 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            early <= '1;
        end else if (state != IDLE && (cnt == 17'd2 || cnt == 17'd1)) begin
            early <= {early[0], rx_s};
        end
    end

    always_comb begin
        bit_val = rx_s;
        if (div_q >= 16'd3) begin
            bit_val = (early[1] & early[0]) | (early[1] & rx_s) | (early[0] & rx_s);
        end
    end
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            armed       <= 1'b0;
            cnt         <= '0;
            div_q       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            rx_m        <= i_rx;
            rx_s        <= rx_m;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed && i_divider != '0) begin
                        armed <= 1'b0;
                        div_q <= i_divider;
                        cnt   <= {1'b0, i_divider} - 17'd1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!bit_val) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            cnt     <= period - 17'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg[bit_idx] <= bit_val;
                        cnt            <= period - 17'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (!bit_val) begin
                            o_frame_err <= 1'b1;
                        end else if (!o_valid || i_ready) begin
                            // A same-cycle handshake frees the register for the new byte.
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 17'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, bytes checked against a scoreboard queue.
module tb_uart_rx;
    logic        i_clk;
    logic        i_rst;
    logic        i_rx;
    logic [15:0] i_divider;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_frame_err;
    logic        o_overrun;

    uart_rx dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .i_divider  (i_divider),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned cyc = 0;
    logic [7:0]  sb[$];

    int unsigned fe_cnt = 0;
    int unsigned ov_cnt = 0;
    int unsigned rise_cnt = 0;
    int unsigned rise_cyc = 0;
    int unsigned vlen = 0;
    int unsigned last_vlen = 0;
    int unsigned busy_run = 0;
    int unsigned busy_max = 0;
    int unsigned frame_start_cyc = 0;
    logic        valid_d = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and tallies flag pulses.
    always @(negedge i_clk) begin
        if (o_frame_err) fe_cnt++;
        if (o_overrun) ov_cnt++;
        if (o_frame_err || o_overrun)
            check("fe_ov_exclusive", 32'(o_frame_err & o_overrun), 32'd0);
        if (o_valid && !valid_d) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        valid_d = o_valid;
        if (o_valid) begin
            vlen++;
        end else begin
            if (vlen != 0) last_vlen = vlen;
            vlen = 0;
        end
        if (o_busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
        if (o_valid && i_ready) begin
            if (sb.size() == 0) check("sb_byte_expected", 32'(sb.size()), 32'd1);
            else check("rx_data", 32'(o_data), 32'(sb.pop_front()));
        end
    end

    // Bit b of {stop, data, start} is inverted for one cycle at its centre when spike[b] is set.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic [9:0] spike,
                              input int unsigned cpb);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        frame_start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            for (int unsigned k = 0; k < cpb; k++) begin
                i_rx = (spike[b] && k == cpb / 2) ? ~bits[b] : bits[b];
                @(posedge i_clk);
                #1;
            end
        end
        i_rx = 1'b1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        int unsigned fe0, ov0, r0, div, per;
        logic [7:0] c6;
        logic [7:0] exp6;
        logic [9:0] mask6;

        i_rst = 1'b1;
        i_rx = 1'b1;
        i_divider = 16'd4;
        i_ready = 1'b1;
        idle(3);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_frame_err", 32'(o_frame_err), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        i_rst = 1'b0;
        idle(5);

        // 0x55 at div=4, consumer always ready
        div = 4;
        per = 2 * div;
        fe0 = fe_cnt;
        r0 = rise_cnt;
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, '0, per);
        idle(10);
        check("t1_rise_count", rise_cnt - r0, 32'd1);
        // two synchroniser cycles before rx_s falls, then t0+div+9P+1
        check("t1_latency", rise_cyc - frame_start_cyc, 2 + div + 9 * per + 1);
        check("t1_valid_width", last_vlen, 32'd1);
        check("t1_no_frame_err", fe_cnt - fe0, 32'd0);

        // 3-cycle low glitch is rejected as a false start
        busy_max = 0;
        r0 = rise_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        i_rx = 1'b0;
        idle(3);
        i_rx = 1'b1;
        idle(20);
        check("t2_busy_bounded", 32'(busy_max >= 1 && busy_max <= 5), 32'd1);
        check("t2_no_valid", rise_cnt - r0, 32'd0);
        check("t2_no_frame_err", fe_cnt - fe0, 32'd0);
        check("t2_no_overrun", ov_cnt - ov0, 32'd0);

        // Low stop bit then a good frame
        fe0 = fe_cnt;
        r0 = rise_cnt;
        send_frame(8'hA3, 1'b0, '0, per);
        idle(20);
        check("t3_frame_err_once", fe_cnt - fe0, 32'd1);
        check("t3_no_valid", rise_cnt - r0, 32'd0);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, '0, per);
        idle(10);
        check("t3_next_frame_valid", rise_cnt - r0, 32'd1);

        // Break: line held low for three frame times gives one frame error only
        fe0 = fe_cnt;
        r0 = rise_cnt;
        i_rx = 1'b0;
        idle(30 * per);
        i_rx = 1'b1;
        idle(20);
        check("brk_frame_err_once", fe_cnt - fe0, 32'd1);
        check("brk_no_valid", rise_cnt - r0, 32'd0);

        // Zero divider disables reception
        i_divider = 16'd0;
        busy_max = 0;
        r0 = rise_cnt;
        send_frame(8'h77, 1'b1, '0, 8);
        idle(10);
        check("div0_never_busy", busy_max, 32'd0);
        check("div0_no_valid", rise_cnt - r0, 32'd0);

        // Back-to-back frames with the consumer stalled
        div = 8;
        per = 2 * div;
        i_divider = 16'd8;
        i_ready = 1'b0;
        ov0 = ov_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, '0, per);
        send_frame(8'h22, 1'b1, '0, per);
        idle(10);
        check("t4_valid_held", 32'(o_valid), 32'd1);
        check("t4_data_held", 32'(o_data), 32'h11);
        check("t4_overrun_once", ov_cnt - ov0, 32'd1);
        i_ready = 1'b1;
        idle(3);
        check("t4_valid_dropped", 32'(o_valid), 32'd0);

        // Reset during data bit 3 with a byte pending
        i_ready = 1'b0;
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, '0, per);
        idle(5);
        check("t5_pending", 32'(o_valid), 32'd1);
        c6 = 8'hC6;
        i_rx = 1'b0;
        idle(per);
        for (int b = 0; b < 3; b++) begin
            i_rx = c6[b];
            idle(per);
        end
        i_rx = c6[3];
        idle(3);
        check("t5_busy_before_rst", 32'(o_busy), 32'd1);
        fe0 = fe_cnt;
        i_rst = 1'b1;
        idle(1);
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_data", 32'(o_data), 32'd0);
        check("t5_rst_busy", 32'(o_busy), 32'd0);
        check("t5_rst_flags", 32'({o_frame_err, o_overrun}), 32'd0);
        i_rst = 1'b0;
        i_rx = 1'b1;
        sb.delete();
        idle(10);
        i_ready = 1'b1;
        r0 = rise_cnt;
        sb.push_back(8'hC6);
        send_frame(8'hC6, 1'b1, '0, per);
        idle(10);
        check("t5_after_rst_valid", rise_cnt - r0, 32'd1);
        check("t5_no_frame_err", fe_cnt - fe0, 32'd0);

        // One-cycle spike at every sampled bit centre
`ifdef UART_RX_MAJORITY_EN
        exp6 = 8'h3C;
        mask6 = 10'h3FF;
`else
        exp6 = 8'hC3;
        mask6 = 10'h1FE;
`endif
        fe0 = fe_cnt;
        r0 = rise_cnt;
        sb.push_back(exp6);
        send_frame(8'h3C, 1'b1, mask6, per);
        idle(10);
        check("t6_valid", rise_cnt - r0, 32'd1);
        check("t6_no_frame_err", fe_cnt - fe0, 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
